// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card constants and sequencer state encoding
package card_pkg;

    localparam int CARD_ROWS    = 12;
    localparam int NCOL_DEFAULT = 80;

    localparam logic [7:0] eNL = 8'h15;
    localparam logic [7:0] eSP = 8'h40;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAT  = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/card_column_seq.sv
// rtl/card_column_seq.sv - card column scan sequencer (optional SKIP_BLANK_EN drops blank columns)
module card_column_seq
    import card_pkg::*;
#(
    parameter int NCOL = NCOL_DEFAULT,
    parameter int AW   = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [AW-1:0]        o_rd_addr,
    input  logic [CARD_ROWS-1:0] i_rd_data,
    output logic [CARD_ROWS-1:0] o_dec_in,
    input  logic [3:0]           i_dec_out,
    input  logic                 i_dec_match,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [AW-1:0]        o_col,
    output logic [CARD_ROWS-1:0] o_data,
    output logic [3:0]           o_code,
    output logic                 o_match,
    output logic [AW:0]          o_err_cnt
);

    state_t                 state, state_nxt;
    logic [AW-1:0]          cnt;
    logic [CARD_ROWS-1:0]   col_q;
    logic [AW-1:0]          col_idx_q;
    logic [CARD_ROWS-1:0]   data_q;
    logic [3:0]             code_q;
    logic                   match_q;
    logic                   first_q;
    logic [AW:0]            err_q;
    logic                   last_col;
    logic                   skip;

    assign last_col = (cnt == AW'(NCOL - 1));

`ifdef SKIP_BLANK_EN
    assign skip = (i_rd_data == '0);
`else
    assign skip = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and state-decoded outputs; abort overrides any transition
    always_comb begin
        state_nxt = state;
        o_rd_en   = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = RD;
            end
            RD: begin
                o_rd_en   = 1'b1;
                o_busy    = 1'b1;
                state_nxt = LAT;
            end
            LAT: begin
                o_busy = 1'b1;
                if (skip) state_nxt = last_col ? DONE : RD;
                else      state_nxt = OUT;
            end
            OUT: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) state_nxt = last_col ? DONE : RD;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (i_abort) state_nxt = IDLE;
    end

    // column counter, column register, beat fields and error count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            col_q     <= '0;
            col_idx_q <= '0;
            data_q    <= '0;
            code_q    <= '0;
            match_q   <= 1'b0;
            first_q   <= 1'b0;
            err_q     <= '0;
        end else if (i_abort) begin
            first_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cnt   <= '0;
                        err_q <= '0;
                    end
                end
                LAT: begin
                    col_q <= i_rd_data;
                    if (skip) begin
                        if (!last_col) cnt <= cnt + 1'b1;
                    end else begin
                        col_idx_q <= cnt;
                        data_q    <= i_rd_data;
                        first_q   <= 1'b1;
                    end
                end
                OUT: begin
                    if (first_q) begin
                        code_q  <= i_dec_out;
                        match_q <= i_dec_match;
                        first_q <= 1'b0;
                        if (!i_dec_match && err_q != {(AW+1){1'b1}}) err_q <= err_q + 1'b1;
                    end
                    if (i_ready && !last_col) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // decoder result is live on the beat's first cycle, then held from the capture
    assign o_code    = first_q ? i_dec_out   : code_q;
    assign o_match   = first_q ? i_dec_match : match_q;
    assign o_rd_addr = cnt;
    assign o_dec_in  = col_q;
    assign o_col     = col_idx_q;
    assign o_data    = data_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_card_column_seq.sv
// tb/tb_card_column_seq.sv - directed scoreboard bench for card_column_seq
module tb_card_column_seq;

    localparam int NCOL = 4;
    localparam int AW   = 3;

    typedef struct packed {
        logic [AW-1:0] col;
        logic [11:0]   data;
        logic [3:0]    code;
        logic          match;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, ready;
    logic          busy, done, rd_en, valid, dec_match, match;
    logic [AW-1:0] rd_addr, col;
    logic [11:0]   rd_data, dec_in, data;
    logic [3:0]    dec_out, code;
    logic [AW:0]   err;

    logic [11:0]   mem [NCOL];
    beat_t         q [$];
    int            total = 0, passed = 0;
    int            cyc = 0, beats = 0, done_cnt = 0;
    int            last_xfer = 0, done_cyc = 0;
    bit            spacing_on = 0, have_prev = 0, skip_mode;

    card_column_seq #(.NCOL(NCOL), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .i_rd_data(rd_data), .o_dec_in(dec_in), .i_dec_out(dec_out),
        .i_dec_match(dec_match), .o_valid(valid), .i_ready(ready),
        .o_col(col), .o_data(data), .o_code(code), .o_match(match),
        .o_err_cnt(err)
    );

    always #5 clk = ~clk;

    // decoder stand-in: fixed lookup, anything unknown is a mismatch
    function automatic logic [4:0] dec(input logic [11:0] d);
        case (d)
            12'h000: return {4'h0, 1'b1};
            12'h900: return {4'h4, 1'b1};
            12'h240: return {4'h6, 1'b1};
            12'h190: return {4'h8, 1'b1};
            12'h001: return {4'h9, 1'b1};
            default: return {4'hF, 1'b0};
        endcase
    endfunction

    assign {dec_out, dec_match} = dec(dec_in);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // beat monitor: pops the scoreboard on each valid&ready
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (q.size() == 0) begin
                chk("beat_unexpected", q.size(), 1);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_col", col, e.col);
                chk("beat_data", data, e.data);
                chk("beat_code", code, e.code);
                chk("beat_match", match, e.match);
            end
            if (spacing_on && have_prev) chk("beat_spacing", cyc - last_xfer, 3);
            have_prev = 1;
            last_xfer = cyc;
            beats++;
        end
        if (!rst && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic load(input logic [11:0] a, b, c, d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
        q.delete();
        for (int i = 0; i < NCOL; i++) begin
            beat_t e;
            if (skip_mode && mem[i] == 12'h000) continue;
            e.col = AW'(i);
            e.data = mem[i];
            {e.code, e.match} = dec(mem[i]);
            q.push_back(e);
        end
    endtask

    task automatic start_card();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        chk("busy_after_start", busy, 1);
        chk("rd_addr_first", rd_addr, 0);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt > d0) break;
        end
        chk("done_seen", done_cnt > d0, 1);
        chk("busy_in_done", busy, 0);
    endtask

    initial begin
        int b0, d0, n;
`ifdef SKIP_BLANK_EN
        skip_mode = 1;
`else
        skip_mode = 0;
`endif
        rst = 1; start = 0; abort = 0; ready = 1;
        mem[0] = 0; mem[1] = 0; mem[2] = 0; mem[3] = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {busy, done, rd_en, valid}, 0);
        chk("rst_fields", {rd_addr, col, data, dec_in, code, match, err}, 0);
        @(posedge clk); #1 rst = 0;

        // card A, free-running ready
        load(12'h900, 12'h240, 12'h190, 12'h001);
        b0 = beats; d0 = done_cnt; have_prev = 0; spacing_on = 1;
        start_card();
        wait_done(d0);
        spacing_on = 0;
        chk("a_beats", beats - b0, 4);
        chk("a_done_lat", done_cyc - last_xfer, 1);
        chk("a_err", err, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // backpressure on column 1
        load(12'h900, 12'h240, 12'h190, 12'h001);
        b0 = beats; d0 = done_cnt;
        start_card();
        for (int i = 0; i < 50 && beats < b0 + 1; i++) @(negedge clk);
        @(posedge clk); #1 ready = 0;
        for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", valid, 1);
            chk("bp_col", col, 1);
            chk("bp_data", data, 12'h240);
            chk("bp_rd_en", rd_en, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 ready = 1;
        wait_done(d0);
        chk("bp_beats", beats - b0, 4);

        // mismatches on columns 1 and 2
        load(12'h900, 12'h123, 12'h456, 12'h001);
        b0 = beats; d0 = done_cnt;
        start_card();
        wait_done(d0);
        chk("err_cnt", err, 2);
        load(12'h900, 12'h240, 12'h190, 12'h001);
        d0 = done_cnt;
        start_card();
        chk("err_cleared", err, 0);
        wait_done(d0);

        // abort in LAT of column 2
        load(12'h900, 12'h240, 12'h190, 12'h001);
        b0 = beats; d0 = done_cnt;
        start_card();
        for (int i = 0; i < 50 && !(rd_en && rd_addr == 2); i++) @(negedge clk);
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort_ctl", {busy, valid, rd_en}, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_beats", beats - b0, 2);
        load(12'h900, 12'h240, 12'h190, 12'h001);
        b0 = beats; d0 = done_cnt;
        start_card();
        wait_done(d0);
        chk("restart_beats", beats - b0, 4);

        // blank columns
        load(12'h000, 12'h900, 12'h000, 12'h000);
        n = skip_mode ? 1 : 4;
        b0 = beats; d0 = done_cnt;
        start_card();
        wait_done(d0);
        chk("blank_beats", beats - b0, n);

        // asynchronous reset while a beat is stalled
        load(12'h900, 12'h240, 12'h190, 12'h001);
        ready = 0; d0 = done_cnt;
        start_card();
        for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
        chk("pre_rst_valid", valid, 1);
        #2 rst = 1;
        #1;
        chk("arst_ctl", {busy, done, rd_en, valid}, 0);
        chk("arst_fields", {rd_addr, col, data, dec_in, code, match, err}, 0);
        @(posedge clk); #1 rst = 0; ready = 1;
        q.delete();
        repeat (5) @(negedge clk);
        chk("arst_idle", busy, 0);
        chk("arst_no_done", done_cnt, d0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
